// File: rtl/bp_update_if.sv
// ----------------------------------------------------------------------------
// bp_update_if
//   Bundles the fetch (allocate), execute (resolve), flush and predictor-update
//   signals of the branch-predictor update controller.
//   master : the environment (fetch, execute, exception logic, predictor)
//   slave  : bp_update_ctrl
//
//   alloc_valid/alloc_pc/alloc_pred  -> slave   fetch pushes a predicted branch
//   alloc_ready                      <- slave   entry can be accepted this cycle
//   resolve_valid/resolve_taken      -> slave   execute resolves the oldest branch
//   resolve_ready                    <- slave   a resolvable entry is queued
//   flush_req                        -> slave   external flush request
//   pu_update/pu_pc/pu_taken         <- slave   predictor training port
//   mispredict                       <- slave   1-cycle mispredict pulse
//   flushing                         <- slave   high while flushing
//   occupancy                        <- slave   valid queue entries
//   branch_cnt/mispred_cnt           <- slave   wrapping statistics counters
// ----------------------------------------------------------------------------
interface bp_update_if #(
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic          alloc_valid;
    logic [31:0]   alloc_pc;
    logic          alloc_pred;
    logic          alloc_ready;
    logic          resolve_valid;
    logic          resolve_taken;
    logic          resolve_ready;
    logic          flush_req;
    logic          pu_update;
    logic [31:0]   pu_pc;
    logic          pu_taken;
    logic          mispredict;
    logic          flushing;
    logic [OW-1:0] occupancy;
    logic [31:0]   branch_cnt;
    logic [31:0]   mispred_cnt;

    modport master (
        output alloc_valid, alloc_pc, alloc_pred,
        output resolve_valid, resolve_taken,
        output flush_req,
        input  alloc_ready, resolve_ready,
        input  pu_update, pu_pc, pu_taken,
        input  mispredict, flushing, occupancy,
        input  branch_cnt, mispred_cnt
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred,
        input  resolve_valid, resolve_taken,
        input  flush_req,
        output alloc_ready, resolve_ready,
        output pu_update, pu_pc, pu_taken,
        output mispredict, flushing, occupancy,
        output branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/bp_update_ctrl.sv
// ----------------------------------------------------------------------------
// bp_update_ctrl
//   Sequences training of the gshare branch predictor. Branches predicted at
//   fetch are pushed into an in-order circular queue; each execute-stage
//   resolve pops the oldest entry, trains the predictor one cycle later and,
//   on a wrong prediction, starts a fixed-length flush that blocks fetch.
//
// Parameters
//   DEPTH         in-flight branch entries (power of two, >= 2)
//   FLUSH_CYCLES  cycles spent in FLUSH (>= 1)
//
// Ports
//   clk    in   rising-edge clock
//   rst_b  in   asynchronous active-low reset
//   bus    slave modport of bp_update_if (handshakes, update port, status)
// ----------------------------------------------------------------------------
module bp_update_ctrl #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    bp_update_if.slave  bus
);

    localparam int PW  = $clog2(DEPTH);
    localparam int OW  = PW + 1;
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e         state_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [OW-1:0]  occ_q;
    logic [FCW-1:0] flush_cnt_q;
    logic           alloc_ready_q;
    logic           resolve_ready_q;
    logic           pu_update_q;
    logic [31:0]    pu_pc_q;
    logic           pu_taken_q;
    logic           mispredict_q;
    logic [31:0]    branch_cnt_q;
    logic [31:0]    mispred_cnt_q;

    logic [31:0]    pc_mem   [DEPTH];
    logic           pred_mem [DEPTH];

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic           alloc_acc;
    logic           res_acc;
    logic [31:0]    head_pc;
    logic           head_pred;
    logic           mispred_hit;
    logic           go_flush;
    logic [PW-1:0]  rd_ptr_d;
    logic [PW-1:0]  wr_ptr_d;
    logic [OW-1:0]  occ_d;

    // NOTE: every signal of a combinational block gets a value on every path;
    // a path that leaves one unassigned infers a latch.
    always_comb begin
        // The ready flags are registered and already zero outside RUN, so
        // an accept can only ever happen in RUN.
        alloc_acc   = bus.alloc_valid & alloc_ready_q;
        res_acc     = bus.resolve_valid & resolve_ready_q;
        head_pc     = pc_mem[rd_ptr_q];
        head_pred   = pred_mem[rd_ptr_q];
        mispred_hit = res_acc & (bus.resolve_taken != head_pred);
        go_flush    = mispred_hit | bus.flush_req;
        // Pointers wrap naturally because DEPTH is a power of two.
        rd_ptr_d    = rd_ptr_q + PW'(res_acc);
        wr_ptr_d    = wr_ptr_q + PW'(alloc_acc);
        occ_d       = occ_q + OW'(alloc_acc) - OW'(res_acc);
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    // NOTE: the entry array is deliberately not reset; validity is carried
    // solely by the pointers and occupancy, which are reset.
    always_ff @(posedge clk) begin
        if (alloc_acc) begin
            pc_mem[wr_ptr_q]   <= bus.alloc_pc;
            pred_mem[wr_ptr_q] <= bus.alloc_pred;
        end
    end

    // ------------------------------------------------------------------
    // FSM, queue control, update port and statistics
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q         <= ST_RUN;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            occ_q           <= '0;
            flush_cnt_q     <= '0;
            alloc_ready_q   <= 1'b1;
            resolve_ready_q <= 1'b0;
            pu_update_q     <= 1'b0;
            pu_pc_q         <= '0;
            pu_taken_q      <= 1'b0;
            mispredict_q    <= 1'b0;
            branch_cnt_q    <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            // The predictor is trained on every resolved branch, including
            // the one that triggers a flush. pu_pc/pu_taken hold otherwise.
            pu_update_q  <= res_acc;
            mispredict_q <= mispred_hit;
            if (res_acc) begin
                pu_pc_q      <= head_pc;
                pu_taken_q   <= bus.resolve_taken;
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispred_hit) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end

            case (state_q)
                ST_RUN: begin
                    if (go_flush) begin
                        // Flush wins over any allocation offered this cycle.
                        state_q         <= ST_FLUSH;
                        rd_ptr_q        <= '0;
                        wr_ptr_q        <= '0;
                        occ_q           <= '0;
                        flush_cnt_q     <= '0;
                        alloc_ready_q   <= 1'b0;
                        resolve_ready_q <= 1'b0;
                    end else begin
                        rd_ptr_q        <= rd_ptr_d;
                        wr_ptr_q        <= wr_ptr_d;
                        occ_q           <= occ_d;
                        // Readiness is computed from next-cycle occupancy so
                        // a resolve on a full queue does not open alloc
                        // in the same cycle.
                        alloc_ready_q   <= (occ_d != OW'(DEPTH));
                        resolve_ready_q <= (occ_d != '0);
                    end
                end
                ST_FLUSH: begin
                    if (bus.flush_req) begin
                        flush_cnt_q <= '0;
                    end else if (flush_cnt_q == FCW'(FLUSH_CYCLES - 1)) begin
                        state_q       <= ST_RUN;
                        flush_cnt_q   <= '0;
                        alloc_ready_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FCW'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------
    assign bus.alloc_ready   = alloc_ready_q;
    assign bus.resolve_ready = resolve_ready_q;
    assign bus.pu_update     = pu_update_q;
    assign bus.pu_pc         = pu_pc_q;
    assign bus.pu_taken      = pu_taken_q;
    assign bus.mispredict    = mispredict_q;
    assign bus.flushing      = (state_q == ST_FLUSH);
    assign bus.occupancy     = occ_q;
    assign bus.branch_cnt    = branch_cnt_q;
    assign bus.mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bp_update_ctrl
//   Directed scenarios followed by a randomized phase. Expected outputs come
//   from a transaction-level model: a queue of {pc, pred} entries, a count of
//   remaining flush cycles and plain counters.
// ----------------------------------------------------------------------------
module tb_bp_update_ctrl;

    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;

    logic clk   = 1'b0;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    bp_update_if #(.DEPTH(DEPTH)) bus ();

    bp_update_ctrl #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        mq[$];
    int          m_flush_left;
    logic        m_pu_update;
    logic [31:0] m_pu_pc;
    logic        m_pu_taken;
    logic        m_mis;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flush_left = 0;
        m_pu_update  = 1'b0;
        m_pu_pc      = '0;
        m_pu_taken   = 1'b0;
        m_mis        = 1'b0;
        m_bcnt       = '0;
        m_mcnt       = '0;
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic run;
        logic a_acc;
        logic r_acc;
        logic mis;
        ent_t e;
        run   = (m_flush_left == 0);
        a_acc = bus.alloc_valid && run && (mq.size() < DEPTH);
        r_acc = bus.resolve_valid && run && (mq.size() > 0);
        mis   = 1'b0;
        m_pu_update = r_acc;
        if (r_acc) begin
            e          = mq[0];
            m_pu_pc    = e.pc;
            m_pu_taken = bus.resolve_taken;
            mis        = (bus.resolve_taken != e.pred);
            m_bcnt     = m_bcnt + 32'd1;
            if (mis) m_mcnt = m_mcnt + 32'd1;
        end
        m_mis = mis;
        if (run) begin
            if (mis || bus.flush_req) begin
                mq.delete();
                m_flush_left = FLUSH_CYCLES;
            end else begin
                if (r_acc) void'(mq.pop_front());
                if (a_acc) mq.push_back('{pc: bus.alloc_pc, pred: bus.alloc_pred});
            end
        end else if (bus.flush_req) begin
            m_flush_left = FLUSH_CYCLES;
        end else begin
            m_flush_left = m_flush_left - 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic run;
        run = (m_flush_left == 0);
        check({tag, "/alloc_ready"},   32'(bus.alloc_ready),   32'(run && (mq.size() < DEPTH)));
        check({tag, "/resolve_ready"}, 32'(bus.resolve_ready), 32'(run && (mq.size() > 0)));
        check({tag, "/pu_update"},     32'(bus.pu_update),     32'(m_pu_update));
        check({tag, "/pu_pc"},         bus.pu_pc,              m_pu_pc);
        check({tag, "/pu_taken"},      32'(bus.pu_taken),      32'(m_pu_taken));
        check({tag, "/mispredict"},    32'(bus.mispredict),    32'(m_mis));
        check({tag, "/flushing"},      32'(bus.flushing),      32'(!run));
        check({tag, "/occupancy"},     32'(bus.occupancy),     32'(mq.size()));
        check({tag, "/branch_cnt"},    bus.branch_cnt,         m_bcnt);
        check({tag, "/mispred_cnt"},   bus.mispred_cnt,        m_mcnt);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/alloc_ready"},   32'(bus.alloc_ready),   32'd1);
        check({tag, "/resolve_ready"}, 32'(bus.resolve_ready), 32'd0);
        check({tag, "/pu_update"},     32'(bus.pu_update),     32'd0);
        check({tag, "/pu_pc"},         bus.pu_pc,              32'd0);
        check({tag, "/pu_taken"},      32'(bus.pu_taken),      32'd0);
        check({tag, "/mispredict"},    32'(bus.mispredict),    32'd0);
        check({tag, "/flushing"},      32'(bus.flushing),      32'd0);
        check({tag, "/occupancy"},     32'(bus.occupancy),     32'd0);
        check({tag, "/branch_cnt"},    bus.branch_cnt,         32'd0);
        check({tag, "/mispred_cnt"},   bus.mispred_cnt,        32'd0);
    endtask

    task automatic drive(input logic av, input logic [31:0] pc, input logic pred,
                         input logic rv, input logic taken, input logic fr);
        bus.alloc_valid   = av;
        bus.alloc_pc      = pc;
        bus.alloc_pred    = pred;
        bus.resolve_valid = rv;
        bus.resolve_taken = taken;
        bus.flush_req     = fr;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: model follows the driven inputs, DUT is sampled 1 ns after the edge.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic        av;
        logic [31:0] pc;
        logic        pred;
        logic        rv;
        logic        taken;
        logic        fr;

        idle();
        model_reset();
        #1 rst_b = 1'b0;
        #1 check_reset_vals("reset");
        @(posedge clk);
        #1 rst_b = 1'b1;
        tick("post_reset");

        // 1: correct prediction, update one cycle after resolve
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("t1_alloc");
        drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("t1_resolve");
        check("t1_pu_pc_const",  bus.pu_pc,            32'h100);
        check("t1_bcnt_const",   bus.branch_cnt,       32'd1);
        check("t1_occ_const",    32'(bus.occupancy),   32'd0);
        idle();
        tick("t1_idle");

        // 2: fill to DEPTH, overflow alloc ignored, resolve+alloc when full
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick("t2_fill");
        end
        check("t2_full_ready", 32'(bus.alloc_ready), 32'd0);
        check("t2_full_occ",   32'(bus.occupancy),   32'd4);
        drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("t2_overflow");
        drive(1'b1, 32'h404, 1'b1, 1'b1, 1'b1, 1'b0);
        tick("t2_alloc_resolve");
        check("t2_occ_after", 32'(bus.occupancy), 32'd3);
        check("t2_pu_pc",     bus.pu_pc,          32'h300);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            tick("t2_drain");
        end
        idle();
        tick("t2_idle");

        // 3: mispredict -> two FLUSH cycles, update still issued
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("t3_alloc");
        drive(1'b1, 32'h204, 1'b1, 1'b1, 1'b1, 1'b0);
        tick("t3_mispredict");
        check("t3_mis_pulse", 32'(bus.mispredict), 32'd1);
        check("t3_flush_c1",  32'(bus.flushing),   32'd1);
        check("t3_pu_pc",     bus.pu_pc,           32'h200);
        idle();
        tick("t3_flush2");
        check("t3_flush_c2",  32'(bus.flushing),   32'd1);
        check("t3_mis_gone",  32'(bus.mispredict), 32'd0);
        tick("t3_run");
        check("t3_flush_end", 32'(bus.flushing),    32'd0);
        check("t3_ready_back",32'(bus.alloc_ready), 32'd1);

        // 4: external flush discards queued entries without updates
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick("t4_fill");
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("t4_flush");
        check("t4_occ", 32'(bus.occupancy), 32'd0);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick("t4_after");
            check("t4_no_update", 32'(bus.pu_update), 32'd0);
        end

        // 5: pointer wrap, pu_pc follows allocation order
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick("t5_alloc");
            drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            tick("t5_resolve");
            check("t5_pu_pc", bus.pu_pc, 32'(4 * i));
        end
        idle();
        tick("t5_idle");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            av   = ($urandom_range(0, 9) < 6);
            pc   = $urandom & 32'hFFFF_FFFC;
            pred = 1'($urandom_range(0, 1));
            rv   = ($urandom_range(0, 9) < 5);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8) taken = mq[0].pred;
            else taken = 1'($urandom_range(0, 1));
            fr   = ($urandom_range(0, 99) < 3);
            drive(av, pc, pred, rv, taken, fr);
            tick("rand");
        end
        idle();
        for (int i = 0; i < FLUSH_CYCLES + 1; i++) tick("rand_settle");

        // 6: asynchronous reset while flushing
        drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("t6_alloc");
        drive(1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("t6_flush");
        check("t6_in_flush", 32'(bus.flushing), 32'd1);
        idle();
        rst_b = 1'b0;
        #2;
        check_reset_vals("t6_async_reset");
        model_reset();
        @(posedge clk);
        #1 rst_b = 1'b1;
        tick("t6_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
